// File: rtl/register_port_sequencer_if.sv
// Command, response and register-file port bundle for the register port sequencer.
// slave is the sequencer's view; master is the view of whatever surrounds it.
interface register_port_sequencer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   // Both channels use one rule: a transfer happens on a rising edge where valid
   // and ready are both 1; once raised, valid and its payload hold until then.
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [1:0]            cmd_op;
   logic [ADDR_WIDTH-1:0] cmd_addr_a;
   logic [ADDR_WIDTH-1:0] cmd_addr_b;
   logic [DATA_WIDTH-1:0] cmd_data;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic [ADDR_WIDTH-1:0] rf_address;
   logic                  rf_write_enable;
   logic [DATA_WIDTH-1:0] rf_write_data;
   logic [DATA_WIDTH-1:0] rf_read_data;

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_data, rsp_ready, rf_read_data,
      output cmd_ready, rsp_valid, rsp_data, rf_address, rf_write_enable, rf_write_data
   );

   modport master (
      output cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_data, rsp_ready, rf_read_data,
      input  cmd_ready, rsp_valid, rsp_data, rf_address, rf_write_enable, rf_write_data
   );
endinterface

// File: rtl/register_port_sequencer.sv
// Runs READ/WRITE/MOVE/SWAP micro-operations through a single-port register file,
// one command in flight, and returns the result on a valid/ready response channel.
module register_port_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   register_port_sequencer_if.slave        bus,
   output logic [2:0]                      state_dbg
);
   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_MOVE  = 2'b10;
   localparam logic [1:0] OP_SWAP  = 2'b11;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ACC_A = 3'd1,
      ACC_B = 3'd2,
      WB_A  = 3'd3,
      RESP  = 3'd4
   } state_t;

   state_t                state, state_next;
   logic [1:0]            op_q;
   logic [ADDR_WIDTH-1:0] addr_a_q, addr_b_q;
   logic [DATA_WIDTH-1:0] data_q, tmp_a_q, tmp_b_q, rsp_data_q;
   logic                  accept;

   assign accept    = bus.cmd_valid && (state == IDLE);
   assign state_dbg = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.cmd_valid) state_next = ACC_A;
         ACC_A:   state_next = (op_q == OP_READ || op_q == OP_WRITE) ? RESP : ACC_B;
         ACC_B:   state_next = (op_q == OP_SWAP) ? WB_A : RESP;
         WB_A:    state_next = RESP;
         RESP:    if (bus.rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // rf_* decode only from state and latched fields, so cmd_* never reaches the file port.
   always_comb begin
      bus.cmd_ready       = 1'b0;
      bus.rsp_valid       = 1'b0;
      bus.rf_address      = '0;
      bus.rf_write_enable = 1'b0;
      bus.rf_write_data   = '0;
      case (state)
         IDLE:  bus.cmd_ready = 1'b1;
         ACC_A: begin
            bus.rf_address = addr_a_q;
            if (op_q == OP_WRITE) begin
               bus.rf_write_enable = 1'b1;
               bus.rf_write_data   = data_q;
            end
         end
         ACC_B: begin
            bus.rf_address      = addr_b_q;
            bus.rf_write_enable = 1'b1;
            bus.rf_write_data   = tmp_a_q;
         end
         WB_A: begin
            bus.rf_address      = addr_a_q;
            bus.rf_write_enable = 1'b1;
            bus.rf_write_data   = tmp_b_q;
         end
         RESP:    bus.rsp_valid = 1'b1;
         default: ;
      endcase
   end

   assign bus.rsp_data = rsp_data_q;

   // In ACC_B the write lands on the closing edge, so the read still shows old b.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q       <= '0;
         addr_a_q   <= '0;
         addr_b_q   <= '0;
         data_q     <= '0;
         tmp_a_q    <= '0;
         tmp_b_q    <= '0;
         rsp_data_q <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               op_q     <= bus.cmd_op;
               addr_a_q <= bus.cmd_addr_a;
               addr_b_q <= bus.cmd_addr_b;
               data_q   <= bus.cmd_data;
            end
            ACC_A: begin
               case (op_q)
                  OP_READ:  rsp_data_q <= bus.rf_read_data;
                  OP_WRITE: rsp_data_q <= data_q;
                  default:  tmp_a_q    <= bus.rf_read_data;
               endcase
            end
            ACC_B: begin
               tmp_b_q <= bus.rf_read_data;
               if (op_q == OP_MOVE) rsp_data_q <= tmp_a_q;
            end
            WB_A:    rsp_data_q <= tmp_a_q;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_register_port_sequencer.sv
// Bench for register_port_sequencer: a behavioural register file, directed command
// vectors, and scoreboards for responses and register-file writes.
module tb_register_port_sequencer;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ACC_B = 3'd2;

   logic clk;
   logic reset;
   logic [2:0] state_dbg;
   logic [DW-1:0] mem [0:(1<<AW)-1];

   register_port_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   register_port_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // single-port register file model: combinational read, write on rising edge
   always @(posedge clk) if (bus.rf_write_enable) mem[bus.rf_address] <= bus.rf_write_data;
   assign bus.rf_read_data = mem[bus.rf_address];

   int checks = 0;
   int failures = 0;
   logic [DW-1:0]    exp_rsp_q[$];
   logic [AW+DW-1:0] exp_wr_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // response monitor: compare on each handshake cycle
   always @(negedge clk) begin
      if (reset && bus.rsp_valid && bus.rsp_ready) begin
         if (exp_rsp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
         else check("rsp_data", 32'(bus.rsp_data), 32'(exp_rsp_q.pop_front()));
      end
   end

   // write monitor: every write-enable cycle must match the next expected write
   always @(negedge clk) begin
      if (reset && bus.rf_write_enable) begin
         if (exp_wr_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
         else check("rf_write", 32'({bus.rf_address, bus.rf_write_data}), 32'(exp_wr_q.pop_front()));
      end
   end

   task automatic exp_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_wr_q.push_back({a, d});
   endtask

   // issue one command, check response latency and write-pulse count; returns with rsp_valid=1
   task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic [DW-1:0] d, input logic [DW-1:0] exp_rsp,
                        input int exp_lat, input int exp_pulses);
      int lat, pulses, guard;
      exp_rsp_q.push_back(exp_rsp);
      bus.cmd_op = op; bus.cmd_addr_a = a; bus.cmd_addr_b = b; bus.cmd_data = d;
      bus.cmd_valid = 1'b1;
      guard = 0;
      while (1) begin
         @(negedge clk);
         if (bus.cmd_ready) break;
         guard++;
         if (guard > 20) begin check("cmd_accept_timeout", 32'd1, 32'd0); break; end
      end
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      lat = 0; pulses = 0;
      while (1) begin
         @(negedge clk);
         if (bus.rf_write_enable) pulses++;
         @(posedge clk); #1;
         lat++;
         if (bus.rsp_valid || lat > 20) break;
      end
      check("rsp_latency", 32'(lat), 32'(exp_lat));
      check("write_pulses", 32'(pulses), 32'(exp_pulses));
   endtask

   task automatic wait_rsp_done();
      int guard = 0;
      while (1) begin
         @(negedge clk);
         if (bus.rsp_valid && bus.rsp_ready) break;
         guard++;
         if (guard > 20) begin check("rsp_done_timeout", 32'd1, 32'd0); break; end
      end
      @(posedge clk); #1;
   endtask

   task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [DW-1:0] d, input logic [DW-1:0] exp_rsp,
                         input int exp_lat, input int exp_pulses);
      issue(op, a, b, d, exp_rsp, exp_lat, exp_pulses);
      wait_rsp_done();
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_write(a, d);
      do_cmd(2'b01, a, 4'd0, d, d, 1, 1);
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
      do_cmd(2'b00, a, 4'd0, 8'h00, exp, 1, 0);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_state"},     32'(state_dbg),           32'(ST_IDLE));
      check({tag, "_cmd_ready"}, 32'(bus.cmd_ready),       32'd1);
      check({tag, "_rsp_valid"}, 32'(bus.rsp_valid),       32'd0);
      check({tag, "_rsp_data"},  32'(bus.rsp_data),        32'd0);
      check({tag, "_rf_we"},     32'(bus.rf_write_enable), 32'd0);
      check({tag, "_rf_addr"},   32'(bus.rf_address),      32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_addr_a = '0; bus.cmd_addr_b = '0;
      bus.cmd_data = '0; bus.rsp_ready = 1'b1;
      #12;
      check_idle("reset");
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check_idle("post_reset");

      // WRITE then READ
      @(posedge clk); #1;
      wr(4'd3, 8'hA5);
      rd(4'd3, 8'hA5);

      // MOVE r2 -> r15 (top register)
      wr(4'd2, 8'h11);
      wr(4'd15, 8'h22);
      exp_write(4'd15, 8'h11);
      do_cmd(2'b10, 4'd2, 4'd15, 8'h00, 8'h11, 2, 1);
      rd(4'd2, 8'h11);
      rd(4'd15, 8'h11);

      // SWAP r4 <-> r9
      wr(4'd4, 8'h5A);
      wr(4'd9, 8'hC3);
      exp_write(4'd9, 8'h5A);
      exp_write(4'd4, 8'hC3);
      do_cmd(2'b11, 4'd4, 4'd9, 8'h00, 8'h5A, 3, 2);
      rd(4'd4, 8'hC3);
      rd(4'd9, 8'h5A);

      // aliased SWAP r7 <-> r7
      wr(4'd7, 8'h3C);
      exp_write(4'd7, 8'h3C);
      exp_write(4'd7, 8'h3C);
      do_cmd(2'b11, 4'd7, 4'd7, 8'h00, 8'h3C, 3, 2);
      rd(4'd7, 8'h3C);

      // response backpressure with a competing command offered
      bus.rsp_ready = 1'b0;
      issue(2'b00, 4'd9, 4'd0, 8'h00, 8'h5A, 1, 0);
      bus.cmd_valid = 1'b1; bus.cmd_op = 2'b01; bus.cmd_addr_a = 4'd9; bus.cmd_data = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         check("hold_rsp_data",  32'(bus.rsp_data),  32'h5A);
         check("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
         @(posedge clk); #1;
      end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      wait_rsp_done();
      check("bp_state_idle", 32'(state_dbg), 32'(ST_IDLE));
      check("bp_cmd_ready",  32'(bus.cmd_ready), 32'd1);
      rd(4'd9, 8'h5A);

      // reset asserted while a SWAP is in ACC_B
      bus.cmd_op = 2'b11; bus.cmd_addr_a = 4'd4; bus.cmd_addr_b = 4'd9; bus.cmd_data = 8'h00;
      bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      @(posedge clk); #1;
      check("midswap_state", 32'(state_dbg), 32'(ST_ACC_B));
      check("midswap_we",    32'(bus.rf_write_enable), 32'd1);
      reset = 1'b0;
      #1;
      check("abort_we",      32'(bus.rf_write_enable), 32'd0);
      check("abort_rf_addr", 32'(bus.rf_address),      32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check_idle("abort");
      @(posedge clk); #1;
      rd(4'd4, 8'hC3);
      rd(4'd9, 8'h5A);

      repeat (3) @(posedge clk);
      check("rsp_queue_empty", 32'(exp_rsp_q.size()), 32'd0);
      check("wr_queue_empty",  32'(exp_wr_q.size()),  32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/register_port_sequencer.md
Name: register_port_sequencer

Overview:
- Initiator for the single-port register file: it accepts register-access commands over a valid/ready interface and drives the file's shared address, write-enable and write-data lines.
- Executes multi-cycle CISC register micro-operations (READ, WRITE, MOVE, SWAP) through the one port, then returns a result over a valid/ready response channel.
- Sits between the instruction decoder/microcode and the register file.

Parameters:
- DATA_WIDTH, 8, bits per register; must match the register file.
- ADDR_WIDTH, 4, register address bits (2**ADDR_WIDTH registers); must match the register file.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  2  00 READ, 01 WRITE, 10 MOVE, 11 SWAP.
- cmd_addr_a  input  ADDR_WIDTH  primary/source register.
- cmd_addr_b  input  ADDR_WIDTH  destination/second register (MOVE, SWAP only).
- cmd_data  input  DATA_WIDTH  write data (WRITE only).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_data  output  DATA_WIDTH  operation result.
- rf_address  output  ADDR_WIDTH  register file address (read and write).
- rf_write_enable  output  1  register file write strobe.
- rf_write_data  output  DATA_WIDTH  register file write data.
- rf_read_data  input  DATA_WIDTH  register file combinational read of rf_address.

Behaviour:
- States: IDLE, ACC_A, ACC_B, WB_A, RESP.
- Reset (reset=0, async):
  - state=IDLE; rsp_data=0; rsp_valid=0.
  - Latched op/addr/data/tmp registers=0.
  - rf_address=0, rf_write_enable=0, rf_write_data=0 immediately.
  - Reset mid-operation aborts it; no further writes are issued.
- Command channel:
  - cmd_ready=1 only in IDLE. Accept = cmd_valid && cmd_ready at a rising edge.
  - On accept, latch op, addr_a, addr_b, data; go to ACC_A.
  - One command in flight; cmd_* are ignored outside IDLE.
- rf_* outputs are driven only from registered state and latched fields; there is no combinational path from cmd_* to rf_*. In IDLE and RESP: rf_address=0, rf_write_enable=0, rf_write_data=0.
- ACC_A: rf_address=addr_a.
  - READ: we=0; capture rf_read_data into rsp_data; go to RESP.
  - WRITE: we=1, wdata=data; rsp_data<=data; go to RESP.
  - MOVE/SWAP: we=0; capture rf_read_data into tmp_a; go to ACC_B.
- ACC_B: rf_address=addr_b, we=1, wdata=tmp_a.
  - The read in the same cycle returns the pre-edge value of b; capture it into tmp_b.
  - MOVE: rsp_data<=tmp_a; go to RESP.
  - SWAP: go to WB_A.
- WB_A (SWAP only): rf_address=addr_a, we=1, wdata=tmp_b; rsp_data<=tmp_a (old value of a); go to RESP.
- RESP: rsp_valid=1 and rsp_data held stable until rsp_valid && rsp_ready at an edge; then go to IDLE.
  - cmd_ready is 0 in RESP, so there is no back-to-back overlap.
  - Minimum command-to-command spacing is (access cycles + 2).
- Latency (accept edge = edge 0): rsp_valid rises after edge 1 (READ/WRITE), edge 2 (MOVE), edge 3 (SWAP). Write pulses are exactly one cycle each: 1 for WRITE, 1 for MOVE, 2 for SWAP.
- Aliasing:
  - MOVE with a==b rewrites the same value.
  - SWAP with a==b performs both writes of the unchanged value; final contents are unchanged and rsp_data=old a.
- Widths are exact and there is no arithmetic. Address and data pass through unmodified. Full ADDR_WIDTH range is legal, including the top register 2**ADDR_WIDTH-1.

Test Plan:
- Reset with reset=0 mid-SWAP (in ACC_B) -> rf_write_enable drops to 0 immediately; after release, state=IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0.
- WRITE a=3, data=0xA5; then READ a=3 -> one we pulse with rf_address=3, wdata=0xA5; READ rsp_data=0xA5, rsp_valid rising after edge 1.
- Preload r2=0x11, r15=0x22; MOVE a=2, b=15 -> single write of 0x11 to address 15, rsp_data=0x11 after edge 2; r2 stays 0x11.
- Preload r4=0x5A, r9=0xC3; SWAP a=4, b=9 -> writes 0x5A to 9, then 0xC3 to 4, on consecutive cycles; rsp_data=0x5A; reading back gives r4=0xC3, r9=0x5A.
- SWAP a=b=7 with r7=0x3C -> r7 remains 0x3C, rsp_data=0x3C, two we pulses both with wdata=0x3C.
- Hold rsp_ready=0 for 5 cycles after a READ -> rsp_valid and rsp_data stable, cmd_ready=0, a new cmd_valid is ignored, no rf writes; asserting rsp_ready completes the handshake and returns to IDLE the next cycle.
